// File: rtl/median_filter_stream.sv
`default_nettype none
// ============================================================================
// median_filter_stream : raster-order 3x3 median filter, interior windows only
// Revision 1.0
// ============================================================================
module median_filter_stream #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_pixel,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_pixel,
  output logic             o_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_COL_TWO  = CW'(2);
  localparam logic [RW-1:0] C_ROW_TWO  = RW'(2);

  typedef logic [WIDTH-1:0] pix_t;

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic          w_accept;
  logic          w_at_interior;
  logic          w_at_last;
  pix_t          w_lb0_rd;
  pix_t          w_lb1_rd;

  pix_t          r_lb0 [IMG_W];
  pix_t          r_lb1 [IMG_W];
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  pix_t          r_win [3][3];
  pix_t          r_s1  [3][3];
  pix_t          r_s2  [3];
  logic          r_win_vld, r_win_last;
  logic          r_s1_vld,  r_s1_last;
  logic          r_s2_vld,  r_s2_last;
  logic          r_out_vld, r_out_last;
  pix_t          r_out_pix;

  assign w_accept      = i_valid & i_enable;
  assign w_at_interior = (r_row >= C_ROW_TWO) && (r_col >= C_COL_TWO);
  assign w_at_last     = (r_row == C_ROW_LAST) && (r_col == C_COL_LAST);
  assign w_lb0_rd      = r_lb0[r_col];
  assign w_lb1_rd      = r_lb1[r_col];

  // Line buffers stay uncleared: rows from an earlier frame are never read for rows >= 2.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_lb0[r_col] <= i_pixel;
      r_lb1[r_col] <= w_lb0_rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_win_vld  <= 1'b0;
      r_win_last <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s2_last  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_pix  <= '0;
      for (int i = 0; i < 3; i++) begin
        r_s2[i] <= '0;
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
          r_s1[i][j]  <= '0;
        end
      end
    end else begin
      r_win_vld  <= w_accept & w_at_interior;
      r_win_last <= w_accept & w_at_last;
      if (w_accept) begin
        // Row 0 of the window is the oldest image row; column 2 is the newest column.
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= w_lb1_rd;
        r_win[1][2] <= w_lb0_rd;
        r_win[2][2] <= i_pixel;
        if (r_col == C_COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      r_s1_vld  <= r_win_vld;
      r_s1_last <= r_win_last;
      for (int i = 0; i < 3; i++) begin
        r_s1[i][0] <= min3(r_win[i][0], r_win[i][1], r_win[i][2]);
        r_s1[i][1] <= med3(r_win[i][0], r_win[i][1], r_win[i][2]);
        r_s1[i][2] <= max3(r_win[i][0], r_win[i][1], r_win[i][2]);
      end

      // Column sort keeps only the anti-diagonal entries the final median needs.
      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_last;
      r_s2[0]   <= max3(r_s1[0][0], r_s1[1][0], r_s1[2][0]);
      r_s2[1]   <= med3(r_s1[0][1], r_s1[1][1], r_s1[2][1]);
      r_s2[2]   <= min3(r_s1[0][2], r_s1[1][2], r_s1[2][2]);

      r_out_vld  <= r_s2_vld;
      r_out_last <= r_s2_vld & r_s2_last;
      if (r_s2_vld) begin
        r_out_pix <= med3(r_s2[0], r_s2[1], r_s2[2]);
      end
    end
  end

  assign o_valid = r_out_vld;
  assign o_pixel = r_out_pix;
  assign o_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_median_filter_stream.sv
`default_nettype none
// ============================================================================
// tb_median_filter_stream : three filter instances driven in lockstep against a window-median model
// Revision 1.0
// ============================================================================
module tb_median_filter_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] pix = 8'd0;

  logic       ov_a, ol_a, ov_b, ol_b, ov_c, ol_c;
  logic [7:0] op_a, op_b;
  logic [0:0] op_c;

  logic       ov [3];
  logic       ol [3];
  logic [7:0] op [3];

  always #5 clk = ~clk;

  median_filter_stream #(.WIDTH(8), .IMG_W(5), .IMG_H(5)) u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_pixel(pix),
    .o_valid(ov_a), .o_pixel(op_a), .o_last(ol_a));

  median_filter_stream #(.WIDTH(8), .IMG_W(8), .IMG_H(6)) u_dut_b (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_pixel(pix),
    .o_valid(ov_b), .o_pixel(op_b), .o_last(ol_b));

  median_filter_stream #(.WIDTH(1), .IMG_W(6), .IMG_H(5)) u_dut_c (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_pixel(pix[0:0]),
    .o_valid(ov_c), .o_pixel(op_c), .o_last(ol_c));

  always_comb begin
    ov[0] = ov_a; ol[0] = ol_a; op[0] = op_a;
    ov[1] = ov_b; ol[1] = ol_b; op[1] = op_b;
    ov[2] = ov_c; ol[2] = ol_c; op[2] = {7'd0, op_c};
  end

  typedef struct {
    int inst;
    int due;
    int val;
    bit last;
  } exp_t;

  int   mw [3] = '{5, 8, 6};
  int   mh [3] = '{5, 6, 5};
  int   mmask [3] = '{255, 255, 1};
  int   mr [3];
  int   mc [3];
  int   hold [3];
  int   img [3][16][16];
  exp_t q [$];
  int   capa [$];
  int   ramp_exp [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
  int   cyc = 0;
  int   last_b = 0;
  int   checks = 0;
  int   errors = 0;

  // 5th smallest by counting: the value with at most 4 strictly below and at least 5 at or below.
  function automatic int med9(input int v[9]);
    for (int i = 0; i < 9; i++) begin
      int nlt = 0;
      int nle = 0;
      for (int j = 0; j < 9; j++) begin
        if (v[j] < v[i])  nlt++;
        if (v[j] <= v[i]) nle++;
      end
      if (nlt <= 4 && nle >= 5) return v[i];
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_accept(input int p);
    for (int k = 0; k < 3; k++) begin
      int r = mr[k];
      int c = mc[k];
      img[k][r][c] = p & mmask[k];
      if (r >= 2 && c >= 2) begin
        int   w [9];
        exp_t e;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[i*3+j] = img[k][r-2+i][c-2+j];
        e.inst = k;
        e.due  = cyc + 4;
        e.val  = med9(w);
        e.last = (r == mh[k]-1) && (c == mw[k]-1);
        q.push_back(e);
      end
      c++;
      if (c == mw[k]) begin
        c = 0;
        r = (r == mh[k]-1) ? 0 : r + 1;
      end
      mr[k] = r;
      mc[k] = c;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ov[0]) capa.push_back(int'(op[0]));
    if (ol[1]) last_b++;
    for (int k = 0; k < 3; k++) begin
      int found = -1;
      for (int i = 0; i < q.size(); i++)
        if (q[i].inst == k && q[i].due == cyc) found = i;
      if (found >= 0) begin
        chk($sformatf("valid[%0d]", k), int'(ov[k]), 1);
        chk($sformatf("pixel[%0d]", k), int'(op[k]), q[found].val);
        chk($sformatf("last[%0d]", k), int'(ol[k]), int'(q[found].last));
        hold[k] = q[found].val;
        q.delete(found);
      end else begin
        chk($sformatf("idle_valid[%0d]", k), int'(ov[k]), 0);
        chk($sformatf("idle_last[%0d]", k), int'(ol[k]), 0);
        chk($sformatf("hold_pixel[%0d]", k), int'(op[k]), hold[k]);
      end
    end
  endtask

  task automatic drive(input int p, input bit v, input bit e);
    pix = p[7:0];
    vld = v;
    en  = e;
    rst = 1'b0;
    if (v && e) model_accept(p);
    tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    vld = 1'b0;
    en  = 1'b0;
    q.delete();
    for (int k = 0; k < 3; k++) begin
      mr[k] = 0; mc[k] = 0; hold[k] = 0;
    end
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic send(input int p, input bit gappy);
    if (gappy) begin
      while ($urandom_range(0, 2) == 0) begin
        int g = int'($urandom_range(0, 2));
        drive(int'($urandom_range(0, 255)), g == 1, g == 0);
      end
    end
    drive(p, 1'b1, 1'b1);
  endtask

  task automatic flush();
    repeat (6) drive(0, 1'b0, 1'b1);
  endtask

  task automatic check_ramp(input string tag);
    chk({tag, "_count"}, capa.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < capa.size()) chk($sformatf("%s_%0d", tag, i), capa[i], ramp_exp[i]);
  endtask

  initial begin
    do_reset(3);

    capa.delete();
    for (int i = 0; i < 25; i++) send(i, 1'b0);
    flush();
    check_ramp("ramp");

    capa.delete();
    for (int i = 0; i < 25; i++) send((i == 12) ? 255 : 50, 1'b0);
    flush();
    chk("spike_count", capa.size(), 9);
    foreach (capa[i]) chk($sformatf("spike_%0d", i), capa[i], 50);

    for (int i = 0; i < 25; i++) send(255, 1'b0);
    for (int i = 0; i < 25; i++) send(0, 1'b0);
    flush();

    capa.delete();
    for (int i = 0; i < 25; i++) send(i, 1'b1);
    flush();
    check_ramp("gappy_ramp");

    begin
      int dup [9] = '{3, 3, 3, 7, 7, 7, 1, 1, 9};
      capa.delete();
      for (int i = 0; i < 25; i++)
        send((i / 5 < 3 && i % 5 < 3) ? dup[(i / 5) * 3 + i % 5] : 0, 1'b0);
      flush();
      chk("dup_count", capa.size(), 9);
      if (capa.size() > 0) chk("dup_median", capa[0], 3);
    end

    capa.delete();
    for (int i = 0; i < 20; i++) send(i, 1'b0);
    do_reset(1);
    flush();
    chk("reset_drop_count", capa.size(), 3);
    capa.delete();
    for (int i = 0; i < 25; i++) send(i, 1'b0);
    flush();
    check_ramp("post_reset_ramp");

    do_reset(2);
    last_b = 0;
    for (int i = 0; i < 96; i++) send(int'($urandom_range(0, 255)), 1'b0);
    flush();
    chk("b_last_count", last_b, 2);

    for (int i = 0; i < 150; i++) send(int'($urandom_range(0, 255)), 1'b1);
    flush();
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/median_filter_stream.md
MEDIAN_FILTER_STREAM -- requirements
Module: median_filter_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning pixel bit width (legal 1..16).
REQ-002 The block SHALL have parameter IMG_W, default 640, meaning pixels per image row (legal >= 3).
REQ-003 The block SHALL have parameter IMG_H, default 480, meaning rows per frame (legal >= 3).
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_enable  input  1  filter enable; when low, the input is not accepted.
REQ-007 i_valid  input  1  i_pixel carries the next raster-order pixel this cycle.
REQ-008 i_pixel  input  WIDTH  unsigned input pixel.
REQ-009 o_valid  output  1  o_pixel carries a median result this cycle (single-cycle pulse per result).
REQ-010 o_pixel  output  WIDTH  unsigned median of one 3x3 window.
REQ-011 o_last  output  1  high together with o_valid on the last result of a frame.

Function
REQ-012 A pixel SHALL be accepted exactly in cycles where i_valid=1 and i_enable=1; no backpressure exists, so every accepted pixel is consumed.
REQ-013 Column counter (0..IMG_W-1) and row counter (0..IMG_H-1) SHALL advance once per accepted pixel; column wraps to 0 and row increments at IMG_W-1; both wrap to 0 after pixel (IMG_H-1, IMG_W-1).
REQ-014 Two line buffers of depth IMG_W SHALL hold the previous two rows; a 3x3 window register SHALL shift by one column per accepted pixel only.
REQ-015 Accepting pixel (r,c) with r>=2 and c>=2 SHALL produce exactly one result, the window centred at (r-1,c-1); all other accepted pixels SHALL produce none (interior-only output, (IMG_H-2)*(IMG_W-2) results per frame).
REQ-016 The result SHALL equal the true median (5th smallest, ties counted by value) of the 9 window pixels.
REQ-017 The median datapath SHALL be pipelined: stage 1 sort each row, stage 2 sort each column, stage 3 median of the anti-diagonal; output is registered.
REQ-018 Latency SHALL be fixed at 4 cycles: pixel accepted in cycle t drives o_valid in cycle t+4, independent of parameters, i_valid gaps and i_enable.
REQ-019 The pipeline SHALL advance every cycle (valid bit carried per stage); bubbles in input produce matching bubbles in output, order preserved.
REQ-020 o_pixel SHALL hold its last result while o_valid=0.
REQ-021 o_last SHALL assert only with the result for pixel (IMG_H-1, IMG_W-1); otherwise 0.
REQ-022 Back-to-back frames: the first two rows of a new frame SHALL yield no output, and line-buffer data from the prior frame SHALL never reach a result.
REQ-023 i_enable low mid-frame SHALL freeze counters and window; in-flight results SHALL still drain at their scheduled cycles.
REQ-024 Arithmetic SHALL be unsigned compare only; no width growth, o_pixel is exactly WIDTH bits.

Reset
REQ-025 While i_reset=1: counters=0, all pipeline valid bits=0, o_valid=0, o_last=0, o_pixel=0, window registers=0.
REQ-026 Line-buffer storage need not be cleared; its contents SHALL be masked by REQ-015/REQ-022.
REQ-027 Reset mid-frame SHALL discard all in-flight results (no o_valid in the cycle after reset is sampled), and the first pixel accepted after reset deasserts SHALL be treated as (0,0).

Verification
REQ-028 IMG_W=5, IMG_H=5, pixel=r*5+c, i_valid continuous -> 9 results 6,7,8,11,12,13,16,17,18; first o_valid 4 cycles after pixel 12 is accepted; o_last with value 18 only.
REQ-029 5x5 frame all 50 except (2,2)=255 -> all 9 results 50; all-255 frame -> all 255; all-0 -> all 0.
REQ-030 Scenario REQ-028 with random i_valid gaps and i_enable toggling -> identical 9-value sequence, each o_valid exactly 4 cycles after its triggering accepted pixel.
REQ-031 Reset pulsed after row 3 of a 5x5 frame -> o_valid=0 from the next cycle, no late results; following fresh frame -> full correct 9 results.
REQ-032 Two back-to-back 8x6 random frames (WIDTH=8), continuous valid -> 2*24 results matching a software 3x3 interior median model, o_last asserted exactly twice.
REQ-033 Duplicate-value windows (e.g. 3,3,3,7,7,7,1,1,9) -> median 3; WIDTH=1 random frame -> majority-of-9 result.
